// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem requests and queues tagged words for IF/ID.
// Optional FETCH_MISALIGN_CHK_EN: misaligned redirect targets halt fetch and raise a sticky misalign_o.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2,
  parameter int unsigned CNT_W    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        misalign_o
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] outst_q, outst_d, drop_q, drop_d;
  logic [31:0]      tag_mem_q [QDEPTH];
  logic [PTR_W-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [63:0]      q_mem_q [QDEPTH];
  logic [PTR_W-1:0] q_wr_q, q_wr_d, q_rd_q, q_rd_d;
  logic [CNT_W-1:0] q_cnt_q, q_cnt_d;
  logic             valid_q, valid_d;
  logic [31:0]      pc_out_q, pc_out_d, inst_out_q, inst_out_d;
  logic [31:0]      redir_pc;
  logic             misalign_q;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_d;
  assign redir_pc = redirect_pc_i;
  always_comb misalign_d = redirect_i ? (|redirect_pc_i[1:0]) : misalign_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end
`else
  assign redir_pc   = redirect_pc_i & 32'hFFFF_FFFC;
  assign misalign_q = 1'b0;
`endif

  logic [CNT_W:0] credit_used;
  logic           fire, rsp_keep, rsp_drop, load_out, q_push, q_pop;
  logic [63:0]    rsp_word;

  // Credits cover both in-flight requests and words parked behind the output register.
  assign credit_used = {1'b0, outst_q} + {1'b0, q_cnt_q};
  assign imem_req_o  = !rst && !redirect_i && !misalign_q && (credit_used < (CNT_W+1)'(QDEPTH));
  assign imem_addr_o = pc_q;
  assign fire        = imem_req_o && imem_gnt_i;
  assign rsp_drop    = imem_rvalid_i && (drop_q != '0);
  assign rsp_keep    = imem_rvalid_i && (drop_q == '0);
  assign rsp_word    = {tag_mem_q[tag_rd_q], imem_rdata_i};
  assign load_out    = !valid_q || !stall_i;

  always_comb begin
    pc_d       = pc_q;
    outst_d    = outst_q + CNT_W'(fire) - CNT_W'(imem_rvalid_i);
    drop_d     = drop_q - CNT_W'(rsp_drop);
    tag_wr_d   = tag_wr_q + PTR_W'(fire);
    tag_rd_d   = tag_rd_q + PTR_W'(rsp_keep);
    q_push     = 1'b0;
    q_pop      = 1'b0;
    valid_d    = valid_q;
    pc_out_d   = pc_out_q;
    inst_out_d = inst_out_q;
    if (fire) pc_d = pc_q + 32'd4;
    if (redirect_i) begin
      pc_d       = redir_pc;
      drop_d     = outst_d;
      tag_wr_d   = '0;
      tag_rd_d   = '0;
      valid_d    = 1'b0;
      pc_out_d   = '0;
      inst_out_d = NOP;
    end else if (load_out) begin
      // Older queued words always go out before a word arriving this cycle.
      if (q_cnt_q != '0) begin
        q_pop                  = 1'b1;
        q_push                 = rsp_keep;
        valid_d                = 1'b1;
        {pc_out_d, inst_out_d} = q_mem_q[q_rd_q];
      end else if (rsp_keep) begin
        valid_d                = 1'b1;
        {pc_out_d, inst_out_d} = rsp_word;
      end else begin
        valid_d    = 1'b0;
        pc_out_d   = '0;
        inst_out_d = NOP;
      end
    end else begin
      q_push = rsp_keep;
    end
    q_wr_d  = redirect_i ? '0 : q_wr_q + PTR_W'(q_push);
    q_rd_d  = redirect_i ? '0 : q_rd_q + PTR_W'(q_pop);
    q_cnt_d = redirect_i ? '0 : q_cnt_q + CNT_W'(q_push) - CNT_W'(q_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      q_wr_q     <= '0;
      q_rd_q     <= '0;
      q_cnt_q    <= '0;
      valid_q    <= 1'b0;
      pc_out_q   <= '0;
      inst_out_q <= NOP;
    end else begin
      pc_q       <= pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      q_wr_q     <= q_wr_d;
      q_rd_q     <= q_rd_d;
      q_cnt_q    <= q_cnt_d;
      valid_q    <= valid_d;
      pc_out_q   <= pc_out_d;
      inst_out_q <= inst_out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fire)   tag_mem_q[tag_wr_q] <= pc_q;
    if (q_push) q_mem_q[q_wr_q]     <= rsp_word;
  end

  assign valid_o    = valid_q;
  assign pc_o       = pc_out_q;
  assign inst_o     = inst_out_q;
  assign misalign_o = misalign_q;

  assert property (@(posedge clk) disable iff (rst) !(q_push && (q_cnt_q == CNT_W'(QDEPTH))));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: an in-order memory responder plus a program-order model of the
// fetch address, presented instruction stream and credit occupancy, checked every cycle.
module tb_fetch_unit;

  localparam int QDEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imemReq, imemGnt = 1'b0, imemRvalid = 1'b0;
  logic [31:0] imemAddr, imemRdata = '0;
  logic        redirect = 1'b0, stall = 1'b0;
  logic [31:0] redirectPc = '0;
  logic        validO, misalignO;
  logic [31:0] pcO, instO;

  fetch_unit #(.RESET_PC(32'h0), .QDEPTH(QDEPTH), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imemReq), .imem_addr_o(imemAddr), .imem_gnt_i(imemGnt),
    .imem_rvalid_i(imemRvalid), .imem_rdata_i(imemRdata),
    .redirect_i(redirect), .redirect_pc_i(redirectPc), .stall_i(stall),
    .valid_o(validO), .pc_o(pcO), .inst_o(instO), .misalign_o(misalignO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          ready;
    bit          stale;
  } pend_t;

  pend_t       pending[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          live = 0;
  int          pops = 0;
  int          queued;
  logic [31:0] expFetch = 32'h0;
  logic [31:0] expOutPc = 32'h0;
  logic [31:0] target;
  logic        expMis = 1'b0;
  logic        expReq;
  pend_t       head;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drives one cycle of inputs just after the clock edge, then waits until mid-cycle outputs settle.
  task automatic applyStimulus(input logic gnt, input logic stl, input logic redir,
                               input logic [31:0] rpc, input int rvPct);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    imemGnt    = gnt;
    stall      = stl;
    redirect   = redir;
    redirectPc = rpc;
    if (pending.size() > 0 && pending[0].ready <= cyc && $urandom_range(0, 99) < rvPct) begin
      imemRvalid = 1'b1;
      imemRdata  = memWord(pending[0].addr);
    end else begin
      imemRvalid = 1'b0;
      imemRdata  = $urandom();
    end
    @(negedge clk);
    #1;
  endtask

  task automatic resetDut();
    @(posedge clk);
    #1;
    rst        = 1'b1;
    imemGnt    = 1'b0;
    stall      = 1'b0;
    redirect   = 1'b0;
    redirectPc = '0;
    imemRvalid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst req", imemReq, 0);
    checkOutput("rst addr", imemAddr, 32'h0);
    checkOutput("rst valid", validO, 0);
    checkOutput("rst pc", pcO, 32'h0);
    checkOutput("rst inst", instO, NOP);
    checkOutput("rst misalign", misalignO, 0);
  endtask

  // Model: every live word is either presented or queued behind the presented one, in program order.
  always @(negedge clk) begin
    if (rst) begin
      pending.delete();
      live     = 0;
      expFetch = 32'h0;
      expOutPc = 32'h0;
      expMis   = 1'b0;
    end else begin
      queued = (live > 0) ? live - 1 : 0;
      expReq = !redirect && !expMis && ((pending.size() + queued) < QDEPTH);
      checkOutput("req", imemReq, expReq);
      checkOutput("addr", imemAddr, expFetch);
      checkOutput("valid", validO, live != 0);
      if (live != 0) begin
        checkOutput("pc", pcO, expOutPc);
        checkOutput("inst", instO, memWord(expOutPc));
      end else begin
        checkOutput("idle pc", pcO, 32'h0);
        checkOutput("idle inst", instO, NOP);
      end
      checkOutput("misalign", misalignO, expMis);

      if (imemRvalid && pending.size() > 0) begin
        head = pending.pop_front();
        if (!head.stale) live++;
      end
      if (imemReq && imemGnt) begin
        pending.push_back('{addr: imemAddr, ready: cyc + 1, stale: 1'b0});
        expFetch = expFetch + 32'd4;
      end
      if (validO && !stall && !redirect) begin
        live--;
        pops++;
        expOutPc = expOutPc + 32'd4;
      end
      if (redirect) begin
`ifdef FETCH_MISALIGN_CHK_EN
        target = redirectPc;
        expMis = |redirectPc[1:0];
`else
        target = redirectPc & 32'hFFFF_FFFC;
        expMis = 1'b0;
`endif
        expFetch = target;
        expOutPc = target;
        live     = 0;
        foreach (pending[i]) pending[i].stale = 1'b1;
      end
    end
  end

  initial begin
    // Streaming from reset with a one-cycle memory.
    resetDut();
    applyStimulus(1, 0, 0, 0, 100);
    checkOutput("t1 addr c0", imemAddr, 32'h0);
    checkOutput("t1 req c0", imemReq, 1);
    applyStimulus(1, 0, 0, 0, 100);
    checkOutput("t1 addr c1", imemAddr, 32'h4);
    applyStimulus(1, 0, 0, 0, 100);
    checkOutput("t1 addr c2", imemAddr, 32'h8);
    checkOutput("t1 valid c2", validO, 1);
    checkOutput("t1 pc c2", pcO, 32'h0);
    checkOutput("t1 inst c2", instO, 32'h1234_A987);
    applyStimulus(1, 0, 0, 0, 100);
    checkOutput("t1 pc c3", pcO, 32'h4);
    applyStimulus(1, 0, 0, 0, 100);
    checkOutput("t1 pc c4", pcO, 32'h8);

    // Five stalled cycles: output frozen on 0xC and credits exhausted.
    repeat (5) applyStimulus(1, 1, 0, 0, 100);
    checkOutput("t2 req", imemReq, 0);
    checkOutput("t2 valid", validO, 1);
    checkOutput("t2 pc", pcO, 32'hC);
    checkOutput("t2 inst", instO, 32'h1238_A98B);
    applyStimulus(1, 0, 0, 0, 100);
    applyStimulus(1, 0, 0, 0, 100);
    checkOutput("t2 pc after", pcO, 32'h10);

    // Redirect with two requests in flight; both responses must vanish.
    resetDut();
    applyStimulus(1, 0, 1, 32'h10, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("t3 addr 10", imemAddr, 32'h10);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("t3 addr 14", imemAddr, 32'h14);
    applyStimulus(1, 0, 1, 32'h200, 0);
    checkOutput("t3 req redirect", imemReq, 0);
    for (int i = 0; i < 30 && !validO; i++) applyStimulus(1, 0, 0, 0, 100);
    checkOutput("t3 first pc", validO ? pcO : 32'hDEAD_BEEF, 32'h200);
    checkOutput("t3 first inst", instO, 32'h1034_AB87);

    // Grant withheld: address and request held.
    resetDut();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 100);
      checkOutput("t4 req", imemReq, 1);
      checkOutput("t4 addr", imemAddr, 32'h0);
    end
    applyStimulus(1, 0, 0, 0, 100);

    // Fetch PC wraps.
    resetDut();
    applyStimulus(1, 0, 1, 32'hFFFF_FFFC, 100);
    applyStimulus(1, 0, 0, 0, 100);
    checkOutput("t5 addr top", imemAddr, 32'hFFFF_FFFC);
    applyStimulus(1, 0, 0, 0, 100);
    checkOutput("t5 addr wrap", imemAddr, 32'h0);
    repeat (4) applyStimulus(1, 0, 0, 0, 100);

`ifdef FETCH_MISALIGN_CHK_EN
    resetDut();
    applyStimulus(1, 0, 1, 32'h102, 100);
    applyStimulus(1, 0, 0, 0, 100);
    checkOutput("t6 misalign", misalignO, 1);
    checkOutput("t6 req off", imemReq, 0);
    applyStimulus(1, 0, 1, 32'h100, 100);
    applyStimulus(1, 0, 0, 0, 100);
    checkOutput("t6 misalign clr", misalignO, 0);
    checkOutput("t6 addr", imemAddr, 32'h100);
    checkOutput("t6 req on", imemReq, 1);
`endif

    // Random traffic: variable grant/latency, stalls and redirects.
    resetDut();
    pops = 0;
    for (int i = 0; i < 3000; i++) begin
      logic        g, s, r;
      logic [31:0] t;
      g = ($urandom_range(0, 99) < 70);
      s = ($urandom_range(0, 99) < 30);
      r = ($urandom_range(0, 99) < 3);
      t = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'h0000_FFFC);
      applyStimulus(g, s, r, t, 60);
      if (i == 1500) resetDut();
    end
    checkOutput("progress", (pops > 200) ? 32'd1 : 32'd0, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
